// File: rtl/i2s_pkg.sv
// Shared encodings for the I2S/TDM receive path.
// No logic of its own: mode values and receiver state encoding only.
// Not applicable (no handshake).
package i2s_pkg;

   localparam logic MODE_I2S = 1'b0;   // data starts one sck after ws falls
   localparam logic MODE_LJ  = 1'b1;   // data starts on the sck that sees ws fall

   typedef enum logic {
      HUNT = 1'b0,   // waiting for the first frame start, all bits discarded
      RUN  = 1'b1    // framed, counting bits and slots
   } rx_state_t;

endpackage

// File: rtl/i2s_rx_fifo.sv
// First-word-fall-through word buffer between the serial decoder and the stream port.
// Latency: a push into an empty buffer is visible on out_valid the next cycle.
// Backpressure: a push into a full buffer is dropped (push_drop) unless a pop happens that cycle.
module i2s_rx_fifo #(
   parameter int WIDTH = 26,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             push_drop,
   input  logic             pop_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             empty;
   logic             full;
   logic             pop;
   logic             wr_en;

   // Pointers carry one wrap bit so full and empty can be told apart.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop       = !empty && pop_ready;
   assign wr_en     = push && (!full || pop);
   assign push_drop = push && full && !pop;

   assign out_valid = !empty;
   // Head word is forced to zero while empty so the port reads 0 out of reset.
   assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer update on accepted push and pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset because empty masks the output.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/i2s_tdm_receive.sv
// I2S / left-justified / TDM serial receiver producing one stream word per channel slot.
// Latency: word enters the buffer one cycle after its last data bit is captured; visible a cycle later.
// Backpressure: words queue in the buffer; when it is full new words are dropped and overflow pulses.
module i2s_tdm_receive
   import i2s_pkg::*;
#(
   parameter int DATA_WIDTH   = 24,
   parameter int SLOT_WIDTH   = 32,
   parameter int NUM_CHANNELS = 2,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                            M_AXIS_ACLK,
   input  logic                            M_AXIS_ARESETN,
   input  logic                            sck,
   input  logic                            ws,
   input  logic                            sd,
   input  logic                            mode,
   output logic                            M_AXIS_TVALID,
   output logic [DATA_WIDTH-1:0]           M_AXIS_TDATA,
   output logic [$clog2(NUM_CHANNELS)-1:0] M_AXIS_TUSER,
   output logic                            M_AXIS_TLAST,
   input  logic                            M_AXIS_TREADY,
   output logic                            overflow,
   output logic                            frame_err
);

   localparam int CW = $clog2(NUM_CHANNELS);
   localparam int BW = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
   localparam int TW = $clog2(NUM_CHANNELS * SLOT_WIDTH + 1) + 1;
   localparam int FW = DATA_WIDTH + CW + 1;

   localparam logic [BW-1:0] LAST_BIT   = BW'(SLOT_WIDTH - 1);
   localparam logic [BW-1:0] LAST_DATA  = BW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] LAST_SLOT  = CW'(NUM_CHANNELS - 1);
   localparam logic [TW-1:0] FRAME_BITS = TW'(NUM_CHANNELS * SLOT_WIDTH);

   logic [2:0]            sck_sync;
   logic [1:0]            ws_sync;
   logic [1:0]            sd_sync;
   logic                  sck_rise;
   logic                  ws_s;
   logic                  sd_s;
   logic                  ws_prev;
   logic                  frame_start;
   logic                  frame_bad;
   logic                  lj_start;
   logic                  i2s_start;
   rx_state_t             state;
   rx_state_t             state_nxt;
   logic [BW-1:0]         bit_cnt;
   logic [BW-1:0]         bit_nxt;
   logic [BW-1:0]         pos_bit;
   logic [CW-1:0]         slot_cnt;
   logic [CW-1:0]         slot_nxt;
   logic [CW-1:0]         pos_slot;
   logic [CW-1:0]         word_slot;
   logic                  extra;
   logic                  extra_nxt;
   logic                  pos_extra;
   logic                  pos_vld;
   logic                  capture;
   logic                  word_done;
   logic [TW-1:0]         tot_cnt;
   logic [DATA_WIDTH-1:0] shift;
   logic                  push;
   logic                  push_drop;
   logic [FW-1:0]         push_data;
   logic [FW-1:0]         out_data;

   // Two-flop synchronisers; sck keeps a third flop as edge-detect history.
   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) begin
         sck_sync <= '0;
         ws_sync  <= '0;
         sd_sync  <= '0;
      end else begin
         sck_sync <= {sck_sync[1:0], sck};
         ws_sync  <= {ws_sync[0], ws};
         sd_sync  <= {sd_sync[0], sd};
      end
   end

   assign sck_rise = sck_sync[1] && !sck_sync[2];
   assign ws_s     = ws_sync[1];
   assign sd_s     = sd_sync[1];

   // Only a sampled ws fall marks a frame; the rising ws edge carries no framing.
   // mode is consulted only here, so a mid-frame change waits for the next frame.
   assign frame_start = sck_rise && ws_prev && !ws_s;
   assign frame_bad   = (tot_cnt != FRAME_BITS);
   assign lj_start    = frame_start && (mode == MODE_LJ);
   assign i2s_start   = frame_start && (mode == MODE_I2S);

   // Receiver state register.
   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) state <= HUNT;
      else                 state <= state_nxt;
   end

   // HUNT leaves on the first frame start and RUN is never left.
   always_comb begin
      state_nxt = state;
      if (frame_start) state_nxt = RUN;
   end

   // Decide which slot/bit the current sck rise represents, and where the counters go next.
   // In I2S mode the frame-start rise still belongs to the previous frame's last bit,
   // unless the frame length was wrong, in which case that bit is thrown away.
   always_comb begin
      pos_vld   = 1'b0;
      pos_bit   = bit_cnt;
      pos_slot  = slot_cnt;
      pos_extra = extra;
      bit_nxt   = bit_cnt;
      slot_nxt  = slot_cnt;
      extra_nxt = extra;
      if (sck_rise) begin
         if (lj_start) begin
            pos_vld   = 1'b1;
            pos_bit   = '0;
            pos_slot  = '0;
            pos_extra = 1'b0;
         end else if (frame_start) begin
            pos_vld = (state == RUN) && !frame_bad;
         end else begin
            pos_vld = (state == RUN);
         end
      end
      if (i2s_start) begin
         bit_nxt   = '0;
         slot_nxt  = '0;
         extra_nxt = 1'b0;
      end else if (pos_vld) begin
         if (pos_bit == LAST_BIT) begin
            bit_nxt = '0;
            if (pos_slot == LAST_SLOT) begin
               slot_nxt  = '0;
               extra_nxt = 1'b1;   // ws frame ran past the last slot
            end else begin
               slot_nxt  = pos_slot + 1'b1;
               extra_nxt = pos_extra;
            end
         end else begin
            bit_nxt   = pos_bit + 1'b1;
            slot_nxt  = pos_slot;
            extra_nxt = pos_extra;
         end
      end
   end

   assign capture   = pos_vld && !pos_extra && (pos_bit <= LAST_DATA);
   assign word_done = capture && (pos_bit == LAST_DATA);

   // Counters, data shift register, frame-length tally and the delayed push.
   always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
      if (!M_AXIS_ARESETN) begin
         ws_prev   <= 1'b0;
         bit_cnt   <= '0;
         slot_cnt  <= '0;
         extra     <= 1'b0;
         tot_cnt   <= '0;
         shift     <= '0;
         word_slot <= '0;
         push      <= 1'b0;
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (sck_rise) ws_prev <= ws_s;
         bit_cnt  <= bit_nxt;
         slot_cnt <= slot_nxt;
         extra    <= extra_nxt;
         if (frame_start)                     tot_cnt <= TW'(1);
         else if (sck_rise && tot_cnt != '1)  tot_cnt <= tot_cnt + 1'b1;
         if (capture)   shift     <= (shift << 1) | DATA_WIDTH'(sd_s);
         if (word_done) word_slot <= pos_slot;
         push      <= word_done;
         overflow  <= push_drop;
         frame_err <= frame_start && (state == RUN) && frame_bad;
      end
   end

   assign push_data = {shift, word_slot, (word_slot == LAST_SLOT)};

   i2s_rx_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (M_AXIS_ACLK),
      .rst_n     (M_AXIS_ARESETN),
      .push      (push),
      .push_data (push_data),
      .push_drop (push_drop),
      .pop_ready (M_AXIS_TREADY),
      .out_valid (M_AXIS_TVALID),
      .out_data  (out_data)
   );

   assign M_AXIS_TDATA = out_data[FW-1 -: DATA_WIDTH];
   assign M_AXIS_TUSER = out_data[CW:1];
   assign M_AXIS_TLAST = out_data[0];

endmodule

// File: tb/tb_i2s_tdm_receive.sv
// Self-checking bench for i2s_tdm_receive: default 2-channel instance plus a 4-slot TDM instance.
// Serial frames are built from word lists; expected words come from the same lists.
// Outputs are sampled on the falling system clock edge.
module tb_i2s_tdm_receive;

   localparam int HALF = 30;

   typedef struct packed {logic [23:0] d; logic u; logic l;} wd_t;
   typedef struct packed {logic [15:0] d; logic [1:0] u; logic l;} wd4_t;

   logic aclk = 1'b0;
   logic arst_n = 1'b0;
   logic sck = 1'b0;
   logic ws = 1'b1;
   logic sd = 1'b0;
   logic mode = 1'b0;
   logic tready = 1'b1;
   logic tready4 = 1'b1;

   logic        tvalid, tuser, tlast, overflow, frame_err;
   logic [23:0] tdata;
   logic        tvalid4, tlast4, overflow4, frame_err4;
   logic [15:0] tdata4;
   logic [1:0]  tuser4;

   wd_t  got_q[$], exp_q[$];
   wd4_t got4_q[$], exp4_q[$];
   int   ov_cnt = 0, fe_cnt = 0;
   int   errors = 0, checks = 0;

   always #5 aclk = ~aclk;

   i2s_tdm_receive dut (
      .M_AXIS_ACLK(aclk), .M_AXIS_ARESETN(arst_n), .sck(sck), .ws(ws), .sd(sd), .mode(mode),
      .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TUSER(tuser), .M_AXIS_TLAST(tlast),
      .M_AXIS_TREADY(tready), .overflow(overflow), .frame_err(frame_err)
   );

   i2s_tdm_receive #(.DATA_WIDTH(16), .SLOT_WIDTH(32), .NUM_CHANNELS(4), .FIFO_DEPTH(8)) dut4 (
      .M_AXIS_ACLK(aclk), .M_AXIS_ARESETN(arst_n), .sck(sck), .ws(ws), .sd(sd), .mode(mode),
      .M_AXIS_TVALID(tvalid4), .M_AXIS_TDATA(tdata4), .M_AXIS_TUSER(tuser4), .M_AXIS_TLAST(tlast4),
      .M_AXIS_TREADY(tready4), .overflow(overflow4), .frame_err(frame_err4)
   );

   // Collect accepted words and count status pulses.
   always @(negedge aclk) begin
      if (tvalid && tready) got_q.push_back({tdata, tuser, tlast});
      if (tvalid4 && tready4) got4_q.push_back({tdata4, tuser4, tlast4});
      if (overflow) ov_cnt++;
      if (frame_err) fe_cnt++;
   end

   task automatic drive_bit(input logic w, input logic d);
      sck = 1'b0;
      ws  = w;
      sd  = d;
      #HALF;
      sck = 1'b1;
      #HALF;
   endtask

   // Rises k0..k1-1 of a ws frame: ws low for the first slot, high afterwards.
   // Data position is k (left-justified) or k-1 (I2S); bits past the data width are random.
   task automatic send_frame(input int nch, input int sw, input int dw, input bit lj,
                             input logic [31:0] w [16], input int k0, input int k1);
      for (int k = k0; k < k1; k++) begin
         int p;
         logic [31:0] cur;
         logic dbit;
         p = lj ? k : k - 1;
         dbit = 1'($urandom);
         if (p >= 0 && (p % sw) < dw && (p / sw) < nch) begin
            cur  = w[p / sw];
            dbit = cur[dw - 1 - (p % sw)];
         end
         drive_bit((k < sw) ? 1'b0 : 1'b1, dbit);
      end
   endtask

   task automatic exp_frame(input logic [31:0] w [16]);
      for (int s = 0; s < 2; s++) begin
         wd_t e;
         e.d = w[s][23:0];
         e.u = 1'(s);
         e.l = (s == 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic rand_words(output logic [31:0] w [16]);
      for (int i = 0; i < 16; i++) w[i] = $urandom & 32'h00FF_FFFF;
   endtask

   task automatic test_reset();
      #36;
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
      checks++; if (tdata !== 24'h0) begin errors++; $display("FAIL reset_tdata: got %h want 0", tdata); end
      checks++; if ({tuser, tlast} !== 2'b00) begin errors++; $display("FAIL reset_tuser_tlast: got %b want 00", {tuser, tlast}); end
      checks++; if ({overflow, frame_err} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {overflow, frame_err}); end
      #20;
      arst_n = 1'b1;
      for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'($urandom));
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL hunt_no_output: got tvalid %b want 0", tvalid); end
   endtask

   task automatic test_i2s_basic();
      logic [31:0] w [16];
      int fe0;
      for (int i = 0; i < 16; i++) w[i] = 32'h0;
      w[0] = 32'h00AB_CDEF;
      w[1] = 32'h0012_3456;
      got_q.delete(); exp_q.delete(); fe0 = fe_cnt;
      mode = 1'b0;
      send_frame(2, 32, 24, 1'b0, w, 0, 64);
      #200;
      exp_frame(w);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL basic_frame_err: got %0d want 0", fe_cnt - fe0); end
   endtask

   task automatic test_random_frames();
      logic [31:0] w [16];
      got_q.delete(); exp_q.delete();
      for (int f = 0; f < 4; f++) begin
         bit lj;
         lj = 1'($urandom_range(0, 1));
         mode = lj;
         rand_words(w);
         send_frame(2, 32, 24, lj, w, 0, 64);
         exp_frame(w);
      end
      #200;
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_frame_err();
      logic [31:0] a [16];
      logic [31:0] c [16];
      wd_t e;
      int fe0;
      got_q.delete(); exp_q.delete(); fe0 = fe_cnt;
      mode = 1'b0;
      rand_words(a);
      rand_words(c);
      send_frame(2, 32, 24, 1'b0, a, 0, 40);
      send_frame(2, 32, 24, 1'b0, c, 0, 64);
      #200;
      e.d = a[0][23:0]; e.u = 1'b0; e.l = 1'b0;
      exp_q.push_back(e);
      exp_frame(c);
      checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL frame_err_pulses: got %0d want 1", fe_cnt - fe0); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL frame_err_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL frame_err_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] w [16];
      int ov0;
      got_q.delete(); exp_q.delete(); ov0 = ov_cnt;
      mode = 1'b0;
      tready = 1'b0;
      for (int f = 0; f < 5; f++) begin
         rand_words(w);
         send_frame(2, 32, 24, 1'b0, w, 0, 64);
         exp_frame(w);
      end
      while (exp_q.size() > 8) exp_q.pop_back();
      #200;
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL stall_tvalid: got %b want 1", tvalid); end
      checks++; if ({tdata, tuser, tlast} !== exp_q[0]) begin errors++; $display("FAIL stall_head: got %h want %h", {tdata, tuser, tlast}, exp_q[0]); end
      #100;
      checks++; if ({tdata, tuser, tlast} !== exp_q[0]) begin errors++; $display("FAIL stall_hold: got %h want %h", {tdata, tuser, tlast}, exp_q[0]); end
      checks++; if (ov_cnt - ov0 != 2) begin errors++; $display("FAIL overflow_pulses: got %0d want 2", ov_cnt - ov0); end
      tready = 1'b1;
      #300;
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL drain_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL drain_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL drain_empty: got tvalid %b want 0", tvalid); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w [16];
      int fe0;
      got_q.delete(); exp_q.delete();
      mode = 1'b0;
      tready = 1'b0;
      rand_words(w);
      send_frame(2, 32, 24, 1'b0, w, 0, 40);
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL pre_reset_tvalid: got %b want 1", tvalid); end
      arst_n = 1'b0;
      #1;
      checks++; if ({tvalid, tdata} !== 25'h0) begin errors++; $display("FAIL async_reset_out: got %h want 0", {tvalid, tdata}); end
      #9;
      send_frame(2, 32, 24, 1'b0, w, 40, 50);
      arst_n = 1'b1;
      send_frame(2, 32, 24, 1'b0, w, 50, 64);
      #200;
      checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL post_reset_quiet: got tvalid %b want 0", tvalid); end
      tready = 1'b1;
      fe0 = fe_cnt;
      rand_words(w);
      send_frame(2, 32, 24, 1'b0, w, 0, 64);
      exp_frame(w);
      #200;
      checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL reset_frame_err: got %0d want 0", fe_cnt - fe0); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL reset_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL reset_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_mode_toggle();
      logic [31:0] w1 [16];
      logic [31:0] w2 [16];
      got_q.delete(); exp_q.delete();
      rand_words(w1);
      rand_words(w2);
      mode = 1'b0;
      send_frame(2, 32, 24, 1'b0, w1, 0, 40);
      mode = 1'b1;
      send_frame(2, 32, 24, 1'b0, w1, 40, 64);
      send_frame(2, 32, 24, 1'b1, w2, 0, 64);
      exp_frame(w1);
      exp_frame(w2);
      #200;
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL toggle_count: got %0d want %0d", got_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL toggle_word%0d: got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_tdm4();
      logic [31:0] w [16];
      mode = 1'b1;
      got4_q.delete(); exp4_q.delete();
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 16; i++) w[i] = (f == 0) ? 32'h1111 * (i + 1) : ($urandom & 32'hFFFF);
         send_frame(4, 32, 16, 1'b1, w, 0, 128);
         for (int s = 0; s < 4; s++) begin
            wd4_t e;
            e.d = w[s][15:0];
            e.u = 2'(s);
            e.l = (s == 3);
            exp4_q.push_back(e);
         end
      end
      #200;
      checks++; if (got4_q.size() != exp4_q.size()) begin errors++; $display("FAIL tdm4_count: got %0d want %0d", got4_q.size(), exp4_q.size()); end
      for (int i = 0; i < exp4_q.size() && i < got4_q.size(); i++) begin
         checks++; if (got4_q[i] !== exp4_q[i]) begin errors++; $display("FAIL tdm4_word%0d: got %h want %h", i, got4_q[i], exp4_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_i2s_basic();
      test_random_frames();
      test_frame_err();
      test_backpressure();
      test_reset_mid();
      test_mode_toggle();
      test_tdm4();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/i2s_tdm_receive.md
I2S_TDM_RECEIVE -- requirements
Module: i2s_tdm_receive

Interface
REQ-001 Parameter DATA_WIDTH, default 24: captured bits per channel word, MSB-first.
REQ-002 Parameter SLOT_WIDTH, default 32: sck periods per channel slot; SHALL satisfy SLOT_WIDTH >= DATA_WIDTH.
REQ-003 Parameter NUM_CHANNELS, default 2: slots per frame; SHALL satisfy 2 <= NUM_CHANNELS <= 16.
REQ-004 Parameter FIFO_DEPTH, default 8: output word buffer depth; SHALL be a power of two and at least 2.
REQ-005 Ports (one clock; reset is asynchronous and active-low):
- M_AXIS_ACLK  in  1  system clock; all logic on its rising edge
- M_AXIS_ARESETN  in  1  asynchronous active-low reset
- sck  in  1  serial bit clock, asynchronous to M_AXIS_ACLK
- ws  in  1  word select / frame sync, asynchronous
- sd  in  1  serial data, asynchronous
- mode  in  1  0 = I2S (one-bit delay), 1 = left-justified/TDM (no delay)
- M_AXIS_TVALID  out  1  word available
- M_AXIS_TDATA  out  DATA_WIDTH  channel word
- M_AXIS_TUSER  out  $clog2(NUM_CHANNELS)  slot index of word
- M_AXIS_TLAST  out  1  word is slot NUM_CHANNELS-1
- M_AXIS_TREADY  in  1  downstream accept
- overflow  out  1  one-cycle pulse: word dropped, FIFO full
- frame_err  out  1  one-cycle pulse: frame length mismatch

Function
REQ-006 sck, ws, sd SHALL each pass a 2-flop synchroniser; sck rise/fall SHALL be detected from synchronised history; M_AXIS_ACLK frequency >= 4x sck.
REQ-007 ws and sd SHALL be sampled only in the cycle an sck rise is detected.
REQ-008 Frame start SHALL be a sampled ws 1->0 transition; ws 0->1 transitions SHALL be ignored for framing.
REQ-009 Bit 0 of slot 0 SHALL be: mode=1, the same sck rise that sampled ws=0 first; mode=0, the next sck rise.
REQ-010 mode SHALL be latched at each frame start; changes mid-frame take effect next frame.
REQ-011 State machine: HUNT (after reset; discards all bits) -> RUN on first frame start; RUN persists; no other states.
REQ-012 In RUN, bit counter 0..SLOT_WIDTH-1 and slot counter 0..NUM_CHANNELS-1 SHALL advance per sck rise; both wrap to 0; slot counter increments on bit-counter wrap.
REQ-013 Bits 0..DATA_WIDTH-1 of a slot SHALL shift in MSB-first; bits DATA_WIDTH..SLOT_WIDTH-1 SHALL be ignored.
REQ-014 One M_AXIS_ACLK cycle after bit DATA_WIDTH-1 is captured, the word with TUSER = slot index and TLAST = (slot == NUM_CHANNELS-1) SHALL be pushed to the FIFO.
REQ-015 Slots beyond NUM_CHANNELS-1 (ws frame longer than expected) SHALL not be pushed.
REQ-016 A frame start in RUN at which total bit count since previous frame start != NUM_CHANNELS*SLOT_WIDTH SHALL pulse frame_err one cycle and resynchronise counters to slot 0, bit 0; partial slot SHALL be discarded.
REQ-017 FIFO: first-word-fall-through; TVALID = non-empty; pop on TVALID && TREADY; TDATA/TUSER/TLAST SHALL hold stable while TVALID && !TREADY.
REQ-018 Push when full SHALL be dropped and pulse overflow, unless a pop occurs in the same cycle, then push SHALL be accepted.
REQ-019 Push into empty FIFO SHALL assert TVALID the following cycle.

Reset
REQ-020 On M_AXIS_ARESETN low, immediately: state HUNT, counters 0, FIFO empty, TVALID/overflow/frame_err 0, TDATA/TUSER/TLAST 0, synchronisers 0.
REQ-021 Reset mid-frame SHALL discard partial words and FIFO contents; after release, no word SHALL be output before a new frame start.

Structure
REQ-022 Shared package i2s_pkg SHALL hold mode encodings (MODE_I2S=0, MODE_LJ=1) and state encoding (HUNT, RUN).
REQ-023 FIFO SHALL be a separate sub-module i2s_rx_fifo (width DATA_WIDTH+$clog2(NUM_CHANNELS)+1, depth FIFO_DEPTH).

Verification
REQ-024 Defaults, mode=0, TREADY=1, slot0=0xABCDEF, slot1=0x123456 -> two words, TUSER 0 then 1, TLAST 0 then 1, values exact.
REQ-025 NUM_CHANNELS=4, SLOT_WIDTH=32, DATA_WIDTH=16, mode=1, slots 0x1111..0x4444 -> four words in order, TLAST only on 0x4444.
REQ-026 Frame start after 40 bits (defaults) -> frame_err pulse once, partial word not output, next full frame output correctly.
REQ-027 TREADY=0 for 5 frames, defaults -> 8 words kept, overflow pulses twice, first 8 words delivered in order on TREADY=1.
REQ-028 Reset asserted mid slot 1, released mid frame -> no output until next ws 1->0, then correct frame.
REQ-029 Toggle mode 0->1 mid-frame -> current frame decoded as I2S, next frame as left-justified.
